// File: rtl/hdsoc_spi_pkg.sv
// Shared types for the hdsoc SPI target: FSM state, SPI mode and default frame width.
package hdsoc_spi_pkg;

  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

endpackage

// File: rtl/hdsoc_spi_target_if.sv
// Byte-side bundle of the SPI target: TX holding-buffer handshake and RX byte strobe.
interface hdsoc_spi_target_if #(
  parameter int DATA_W = hdsoc_spi_pkg::DEF_DATA_W
);

  logic [DATA_W-1:0] din_i;
  logic              din_valid_i;
  logic              din_ready_o;
  logic [DATA_W-1:0] dout_o;
  logic              dout_valid_o;

  modport master (
    output din_i,
    output din_valid_i,
    input  din_ready_o,
    input  dout_o,
    input  dout_valid_o
  );

  modport slave (
    input  din_i,
    input  din_valid_i,
    output din_ready_o,
    output dout_o,
    output dout_valid_o
  );

endinterface

// File: rtl/hdsoc_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input, with rise/fall pulses.
// Latency: SYNC_STAGES cycles to q, edge pulses in the same cycle q changes.
// Backpressure: none; free-running.
module hdsoc_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      edge_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q    = sync_q[SYNC_STAGES-1];
  assign rise = q & ~edge_q;
  assign fall = ~q & edge_q;

endmodule

// File: rtl/hdsoc_spi_target.sv
// SPI target endpoint, all CPOL/CPHA modes, oversampled by clk_i; HDSOC_SPI_TGT_STATUS_EN adds overrun/underrun.
// Latency: dout_valid_o one cycle after the synchronised last sample edge; miso follows shift edges by SYNC_STAGES+1.
// Backpressure: none toward the SPI host; din_ready_o drops while the one-entry TX buffer is full.
module hdsoc_spi_target
  import hdsoc_spi_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cpol_i,
  input  logic                cpha_i,
  hdsoc_spi_target_if.slave   bus,
  output logic                busy_o,
  input  logic                sclk_i,
  input  logic                ss_ni,
  input  logic                mosi_i,
  output logic                miso_o,
  output logic                miso_oe_o
`ifdef HDSOC_SPI_TGT_STATUS_EN
  ,
  output logic                overrun_o,
  output logic                underrun_o
`endif
);

  localparam int CNT_W = $clog2(DATA_W);

  spi_mode_t mode;
  assign mode.cpol = cpol_i;
  assign mode.cpha = cpha_i;

  logic ss_q, ss_rise, ss_fall;
  logic sclk_q, sclk_rise, sclk_fall;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic mosi_s;

  hdsoc_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d     (ss_ni),
    .q     (ss_q),
    .rise  (ss_rise),
    .fall  (ss_fall)
  );

  hdsoc_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d     (sclk_i),
    .q     (sclk_q),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  // mosi is delayed by the same depth as sclk so the sample lines up with the detected edge
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mosi_sync <= '0;
    end else begin
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
    end
  end
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // An edge is leading when sclk has just left its idle level
  logic sclk_toggle, lead_edge, trail_edge, sample_edge, shift_edge;
  assign sclk_toggle = sclk_rise | sclk_fall;
  assign lead_edge   = sclk_toggle & (sclk_q ^ mode.cpol);
  assign trail_edge  = sclk_toggle & ~(sclk_q ^ mode.cpol);
  assign sample_edge = mode.cpha ? trail_edge : lead_edge;
  assign shift_edge  = mode.cpha ? lead_edge  : trail_edge;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              byte_done_q;
  logic [DATA_W-1:0] rx_sr, tx_sr, dout_q, buf_q;
  logic              buf_full_q, dout_vld_q, miso_q;
  logic              do_load, do_sample, do_shift, do_clear;
  logic [DATA_W-1:0] load_val, rx_next;

  assign load_val = buf_full_q ? buf_q : '0;
  assign rx_next  = {rx_sr[DATA_W-2:0], mosi_s};

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    do_load   = 1'b0;
    do_sample = 1'b0;
    do_shift  = 1'b0;
    do_clear  = 1'b0;
    if (ss_rise) begin
      state_d  = IDLE;
      do_clear = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (ss_fall) state_d = LOAD;
        end
        LOAD: begin
          do_load = 1'b1;
          state_d = ACTIVE;
        end
        ACTIVE: begin
          if (sample_edge) begin
            do_sample = 1'b1;
          end else if (shift_edge) begin
            // counter==0 before any completed byte is the CPHA=1 first leading edge
            if (cnt_q != '0) do_shift = 1'b1;
            else if (byte_done_q) do_load = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q       <= '0;
      byte_done_q <= 1'b0;
      rx_sr       <= '0;
      tx_sr       <= '0;
      miso_q      <= 1'b0;
      dout_q      <= '0;
      dout_vld_q  <= 1'b0;
    end else begin
      dout_vld_q <= 1'b0;
      if (do_clear || state_q == IDLE) begin
        cnt_q       <= '0;
        byte_done_q <= 1'b0;
        miso_q      <= 1'b0;
      end
      if (do_load) begin
        tx_sr  <= load_val;
        miso_q <= load_val[DATA_W-1];
      end
      if (do_shift) begin
        tx_sr  <= tx_sr << 1;
        miso_q <= tx_sr[DATA_W-2];
      end
      if (do_sample) begin
        rx_sr <= rx_next;
        if (cnt_q == CNT_W'(DATA_W-1)) begin
          cnt_q       <= '0;
          byte_done_q <= 1'b1;
          dout_q      <= rx_next;
          dout_vld_q  <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // A load in the same cycle as an accept leaves the buffer empty
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      buf_full_q <= 1'b0;
      buf_q      <= '0;
    end else if (do_load) begin
      buf_full_q <= 1'b0;
    end else if (bus.din_valid_i && !buf_full_q) begin
      buf_full_q <= 1'b1;
      buf_q      <= bus.din_i;
    end
  end

  assign bus.din_ready_o  = ~buf_full_q;
  assign bus.dout_o       = dout_q;
  assign bus.dout_valid_o = dout_vld_q;
  assign busy_o           = ~ss_q;
  assign miso_oe_o        = ~ss_q;
  assign miso_o           = miso_q;

`ifdef HDSOC_SPI_TGT_STATUS_EN
  logic underrun_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      underrun_q <= 1'b0;
    end else if (do_clear) begin
      underrun_q <= 1'b0;
    end else if (do_load && !buf_full_q) begin
      underrun_q <= 1'b1;
    end
  end

  // No RX backpressure exists yet, so overrun cannot occur
  assign overrun_o  = 1'b0;
  assign underrun_o = underrun_q;
`endif

endmodule

// File: tb/tb_hdsoc_spi_target.sv
// Directed bench for hdsoc_spi_target: bit-banged SPI master in all modes plus byte-side handshake.
module tb_hdsoc_spi_target;
  import hdsoc_spi_pkg::*;

  localparam int H = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cpol = 1'b0, cpha = 1'b0;
  logic sclk = 1'b0, ss_n = 1'b1, mosi = 1'b0;
  logic busy, miso, miso_oe;
`ifdef HDSOC_SPI_TGT_STATUS_EN
  logic overrun, underrun;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int n_pulse = 0;
  logic [7:0] dq[$];

  hdsoc_spi_target_if #(.DATA_W(8)) bus ();

  hdsoc_spi_target #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk_i      (clk),
    .rst_i      (rst_n),
    .cpol_i     (cpol),
    .cpha_i     (cpha),
    .bus        (bus),
    .busy_o     (busy),
    .sclk_i     (sclk),
    .ss_ni      (ss_n),
    .mosi_i     (mosi),
    .miso_o     (miso),
    .miso_oe_o  (miso_oe)
`ifdef HDSOC_SPI_TGT_STATUS_EN
    ,
    .overrun_o  (overrun),
    .underrun_o (underrun)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && bus.dout_valid_o) begin
      n_pulse++;
      dq.push_back(bus.dout_o);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    logic ok;
    ok = 1'b0;
    bus.din_i       = b;
    bus.din_valid_i = 1'b1;
    for (int i = 0; i < 4000 && !ok; i++) begin
      ok = bus.din_ready_o;
      @(negedge clk);
    end
    bus.din_valid_i = 1'b0;
    check("push_accept", ok, 1);
  endtask

  task automatic ss_low();
    ss_n = 1'b0;
    clks(10);
  endtask

  task automatic ss_high();
    clks(H);
    ss_n = 1'b1;
    clks(10);
  endtask

  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        mosi = tx[7-i];
        clks(H);
        rx = {rx[6:0], miso};
        sclk = ~cpol;
        clks(H);
        sclk = cpol;
      end else begin
        clks(H);
        sclk = ~cpol;
        mosi = tx[7-i];
        clks(H);
        rx = {rx[6:0], miso};
        sclk = cpol;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r;
    logic [7:0] rb[3];
    int p0;
    bus.din_i = 8'h00;
    bus.din_valid_i = 1'b0;

    clks(3);
    check("rst_din_ready", bus.din_ready_o, 1);
    check("rst_dout", bus.dout_o, 0);
    check("rst_dout_valid", bus.dout_valid_o, 0);
    check("rst_busy", busy, 0);
    check("rst_miso", miso, 0);
    check("rst_miso_oe", miso_oe, 0);
    rst_n = 1'b1;
    clks(5);

    // mode 0, single byte
    push(8'hA5);
    check("t1_ready_full", bus.din_ready_o, 0);
    p0 = n_pulse;
    ss_low();
    check("t1_busy", busy, 1);
    check("t1_oe", miso_oe, 1);
    check("t1_ready_after_load", bus.din_ready_o, 1);
    xfer(8'h3C, 8, r);
    check("t1_master_rx", r, 8'hA5);
    ss_high();
    check("t1_pulses", n_pulse - p0, 1);
    check("t1_dout", bus.dout_o, 8'h3C);
    check("t1_busy_end", busy, 0);

    // modes 1..3
    for (int m = 1; m < 4; m++) begin
      cpol = m[1];
      cpha = m[0];
      sclk = cpol;
      clks(10);
      push(8'h7E);
      p0 = n_pulse;
      ss_low();
      xfer(8'h81, 8, r);
      ss_high();
      check($sformatf("mode%0d_master_rx", m), r, 8'h7E);
      check($sformatf("mode%0d_dout", m), bus.dout_o, 8'h81);
      check($sformatf("mode%0d_pulses", m), n_pulse - p0, 1);
    end

    cpol = 1'b0;
    cpha = 1'b0;
    sclk = 1'b0;
    clks(10);

    // back-to-back bytes with buffer refill
    push(8'h11);
    p0 = n_pulse;
    ss_low();
    fork
      begin
        push(8'h22);
        push(8'h33);
      end
      begin
        xfer(8'hE1, 8, rb[0]);
        xfer(8'hE2, 8, rb[1]);
        xfer(8'hE3, 8, rb[2]);
      end
    join
    ss_high();
    check("b2b_pulses", n_pulse - p0, 3);
    check("b2b_rx0", rb[0], 8'h11);
    check("b2b_rx1", rb[1], 8'h22);
    check("b2b_rx2", rb[2], 8'h33);
    check("b2b_dout0", dq[p0], 8'hE1);
    check("b2b_dout1", dq[p0+1], 8'hE2);
    check("b2b_dout2", dq[p0+2], 8'hE3);

    // empty buffer at frame start
    p0 = n_pulse;
    ss_low();
`ifdef HDSOC_SPI_TGT_STATUS_EN
    check("ur_set", underrun, 1);
`endif
    xfer(8'h55, 8, r);
`ifdef HDSOC_SPI_TGT_STATUS_EN
    check("ur_held", underrun, 1);
`endif
    ss_high();
`ifdef HDSOC_SPI_TGT_STATUS_EN
    check("ur_cleared", underrun, 0);
    check("overrun_zero", overrun, 0);
`endif
    check("ur_master_rx", r, 8'h00);
    check("ur_dout", bus.dout_o, 8'h55);
    check("ur_pulses", n_pulse - p0, 1);

    // frame aborted after 5 sclk cycles
    p0 = n_pulse;
    ss_low();
    xfer(8'hFF, 5, r);
    ss_high();
    check("ab_pulses", n_pulse - p0, 0);
    check("ab_state", dut.state_q, IDLE);
    check("ab_busy", busy, 0);
    check("ab_miso", miso, 0);
    check("ab_oe", miso_oe, 0);
    push(8'h69);
    p0 = n_pulse;
    ss_low();
    xfer(8'hC3, 8, r);
    ss_high();
    check("ab_next_master_rx", r, 8'h69);
    check("ab_next_dout", bus.dout_o, 8'hC3);
    check("ab_next_pulses", n_pulse - p0, 1);

    // reset mid-byte
    push(8'hF0);
    p0 = n_pulse;
    ss_low();
    xfer(8'hAA, 3, r);
    clks(2);
    check("mr_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mr_din_ready", bus.din_ready_o, 1);
    check("mr_dout", bus.dout_o, 0);
    check("mr_dout_valid", bus.dout_valid_o, 0);
    check("mr_busy", busy, 0);
    check("mr_miso", miso, 0);
    check("mr_miso_oe", miso_oe, 0);
    ss_n = 1'b1;
    sclk = cpol;
    clks(5);
    rst_n = 1'b1;
    clks(5);
    check("mr_pulses", n_pulse - p0, 0);
    push(8'hC5);
    p0 = n_pulse;
    ss_low();
    xfer(8'h5A, 8, r);
    ss_high();
    check("mr_next_master_rx", r, 8'hC5);
    check("mr_next_dout", bus.dout_o, 8'h5A);
    check("mr_next_pulses", n_pulse - p0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
